// File: rtl/dft_result_capture_pkg.sv
// Shared constants, FSM state type and lane helpers for the DFT result capture block.
package dft_result_capture_pkg;
    localparam int NWORDS = 32;
    localparam int DW     = 16;
    localparam int AW     = $clog2(NWORDS);
    localparam int PW     = 2 * DW;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, COMMIT} state_t;

    // Y lanes are packed {Y3,Y2,Y1,Y0}; complex lane n is (re=Y(2n), im=Y(2n+1)).
    function automatic logic signed [DW-1:0] y_part(input logic [4*DW-1:0] y, input int idx);
        return y[idx*DW +: DW];
    endfunction

    function automatic logic [2*PW-1:0] pack_pwr(input logic [PW-1:0] l1, input logic [PW-1:0] l0);
        return {l1, l0};
    endfunction
endpackage

// File: rtl/dft_result_capture_if.sv
// Frame input, readback bus and frame status handshake of the DFT result capture block.
interface dft_result_capture_if;
    import dft_result_capture_pkg::*;

    logic              next_out_i;
    logic [4*DW-1:0]   y_i;
    logic [AW-1:0]     rd_addr_i;
    logic              frame_ack_i;
    logic [4*DW-1:0]   rd_data_o;
    logic [2*PW-1:0]   rd_pwr_o;
    logic [AW:0]       peak_idx_o;
    logic [PW-1:0]     peak_pwr_o;
    logic              frame_valid_o;
    logic              overrun_o;

    modport master (
        output next_out_i, y_i, rd_addr_i, frame_ack_i,
        input  rd_data_o, rd_pwr_o, peak_idx_o, peak_pwr_o, frame_valid_o, overrun_o
    );

    modport slave (
        input  next_out_i, y_i, rd_addr_i, frame_ack_i,
        output rd_data_o, rd_pwr_o, peak_idx_o, peak_pwr_o, frame_valid_o, overrun_o
    );
endinterface

// File: rtl/dft_result_capture_pwr2.sv
// Two-stage pipelined re^2 + im^2 for one complex lane; result is unsigned and never wraps.
module dft_pwr2
    import dft_result_capture_pkg::*;
(
    input  logic                 clk,
    input  logic signed [DW-1:0] re_i,
    input  logic signed [DW-1:0] im_i,
    output logic        [PW-1:0] pwr_o
);
    logic signed [PW-1:0] re_sq, im_sq;
    logic [PW-1:0] re2_p1_d, re2_p1_q, im2_p1_d, im2_p1_q;
    logic [PW-1:0] pwr_p2_d, pwr_p2_q;

    always_comb begin
        re_sq    = PW'(re_i) * PW'(re_i);
        im_sq    = PW'(im_i) * PW'(im_i);
        re2_p1_d = unsigned'(re_sq);
        im2_p1_d = unsigned'(im_sq);
        // Each square is at most 2^30, so the sum fits in 32 bits unsigned.
        pwr_p2_d = re2_p1_q + im2_p1_q;
    end

    // stage p1: squares, stage p2: sum
    always_ff @(posedge clk) begin
        re2_p1_q <= re2_p1_d;
        im2_p1_q <= im2_p1_d;
        pwr_p2_q <= pwr_p2_d;
    end

    assign pwr_o = pwr_p2_q;
endmodule

// File: rtl/dft_result_capture.sv
// Captures one DFT output frame per next_out rising edge into a ping-pong buffer,
// tracks the peak-power bin and holds the committed frame until software acks it.
module dft_result_capture
    import dft_result_capture_pkg::*;
(
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    dft_result_capture_if.slave bus
);
    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              drain_q, drain_d;
    logic              prev_q;
    logic              cap_bank_q, cap_bank_d;
    logic              has_frame_q, has_frame_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [AW:0]       peak_idx_q, peak_idx_d, run_idx_q, run_idx_d;
    logic [PW-1:0]     peak_pwr_q, peak_pwr_d, run_pwr_q, run_pwr_d;
    logic              vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [AW-1:0]     addr_p1_q, addr_p1_d, addr_p2_q, addr_p2_d;
    logic [4*DW-1:0]   rd_data_q, rd_data_d;
    logic [2*PW-1:0]   rd_pwr_q, rd_pwr_d;

    logic [4*DW-1:0]   data_mem [2*NWORDS];
    logic [2*PW-1:0]   pwr_mem  [2*NWORDS];

    logic              edge_w, cap_we, pwr_we, best_lane1;
    logic [PW-1:0]     pwr0, pwr1, best_pwr;
    logic [AW:0]       best_idx;

    dft_pwr2 u_pwr_l0 (.clk(wb_clk_i), .re_i(y_part(bus.y_i, 0)), .im_i(y_part(bus.y_i, 1)), .pwr_o(pwr0));
    dft_pwr2 u_pwr_l1 (.clk(wb_clk_i), .re_i(y_part(bus.y_i, 2)), .im_i(y_part(bus.y_i, 3)), .pwr_o(pwr1));

    // A restart edge suppresses the write of that cycle and flushes in-flight powers.
    assign edge_w     = bus.next_out_i & ~prev_q;
    assign cap_we     = (state_q == CAPTURE) && !edge_w;
    assign pwr_we     = vld_p2_q && !edge_w;
    assign best_lane1 = pwr1 > pwr0;
    assign best_pwr   = best_lane1 ? pwr1 : pwr0;
    assign best_idx   = {addr_p2_q, best_lane1};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        cap_bank_d  = cap_bank_q;
        has_frame_d = has_frame_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        peak_idx_d  = peak_idx_q;
        peak_pwr_d  = peak_pwr_q;
        run_idx_d   = run_idx_q;
        run_pwr_d   = run_pwr_q;
        vld_p1_d    = cap_we;
        addr_p1_d   = cnt_q;
        vld_p2_d    = vld_p1_q && !edge_w;
        addr_p2_d   = addr_p1_q;

        if (pwr_we && (best_pwr > run_pwr_q)) begin
            run_pwr_d = best_pwr;
            run_idx_d = best_idx;
        end
        if (edge_w) begin
            run_pwr_d = '0;
            run_idx_d = '0;
        end

        // Ack is resolved before a same-cycle commit looks at the valid flag.
        if (bus.frame_ack_i && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (edge_w) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end
            end
            CAPTURE: begin
                if (edge_w) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == AW'(NWORDS - 1)) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (edge_w) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else if (drain_q) begin
                    state_d = COMMIT;
                end else begin
                    drain_d = 1'b1;
                end
            end
            COMMIT: begin
                if (!valid_d) begin
                    cap_bank_d  = ~cap_bank_q;
                    peak_idx_d  = run_idx_q;
                    peak_pwr_d  = run_pwr_q;
                    valid_d     = 1'b1;
                    has_frame_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = edge_w ? CAPTURE : IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        rd_data_d = has_frame_q ? data_mem[{~cap_bank_q, bus.rd_addr_i}] : '0;
        rd_pwr_d  = has_frame_q ? pwr_mem[{~cap_bank_q, bus.rd_addr_i}] : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            prev_q      <= 1'b0;
            cap_bank_q  <= 1'b1;
            has_frame_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            peak_idx_q  <= '0;
            peak_pwr_q  <= '0;
            run_idx_q   <= '0;
            run_pwr_q   <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            addr_p1_q   <= '0;
            addr_p2_q   <= '0;
            rd_data_q   <= '0;
            rd_pwr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            prev_q      <= bus.next_out_i;
            cap_bank_q  <= cap_bank_d;
            has_frame_q <= has_frame_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            peak_idx_q  <= peak_idx_d;
            peak_pwr_q  <= peak_pwr_d;
            run_idx_q   <= run_idx_d;
            run_pwr_q   <= run_pwr_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            addr_p1_q   <= addr_p1_d;
            addr_p2_q   <= addr_p2_d;
            rd_data_q   <= rd_data_d;
            rd_pwr_q    <= rd_pwr_d;
        end
    end

    // Bank storage; the bank bit is the address MSB.
    always_ff @(posedge wb_clk_i) begin
        if (cap_we) data_mem[{cap_bank_q, cnt_q}] <= bus.y_i;
        if (pwr_we) pwr_mem[{cap_bank_q, addr_p2_q}] <= pack_pwr(pwr1, pwr0);
    end

    assign bus.rd_data_o     = rd_data_q;
    assign bus.rd_pwr_o      = rd_pwr_q;
    assign bus.peak_idx_o    = peak_idx_q;
    assign bus.peak_pwr_o    = peak_pwr_q;
    assign bus.frame_valid_o = valid_q;
    assign bus.overrun_o     = overrun_q;
endmodule

// File: tb/tb_dft_result_capture.sv
// Self-checking bench for dft_result_capture: directed vector table, corner sequences
// and randomized frames checked against a bin-level behavioural model.
module tb_dft_result_capture;
    import dft_result_capture_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    dft_result_capture_if bus();

    dft_result_capture dut (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] wbuf    [NWORDS];
    logic [63:0] m_frame [NWORDS];
    bit          m_has, m_valid, m_ovr;
    logic [5:0]  m_pidx;
    logic [31:0] m_ppwr;

    typedef struct {
        string       name;
        int          a;
        logic [63:0] ya;
        int          b;
        logic [63:0] yb;
        logic [5:0]  eidx;
        logic [31:0] epwr;
        logic [63:0] epwr_a;
    } vec_t;
    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic longint lane_pwr(input logic [63:0] w, input int lane);
        longint re, im;
        re = longint'($signed(w[32*lane +: 16]));
        im = longint'($signed(w[32*lane+16 +: 16]));
        return re * re + im * im;
    endfunction

    task automatic model_reset();
        m_has = 0; m_valid = 0; m_ovr = 0; m_pidx = '0; m_ppwr = '0;
        for (int k = 0; k < NWORDS; k++) m_frame[k] = '0;
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endtask

    task automatic model_commit();
        longint best, p;
        if (m_valid) begin
            m_ovr = 1;
        end else begin
            best = 0;
            m_pidx = '0;
            for (int b = 0; b < 2*NWORDS; b++) begin
                p = lane_pwr(wbuf[b/2], b % 2);
                if (p > best) begin
                    best = p;
                    m_pidx = 6'(b);
                end
            end
            m_ppwr  = 32'(best);
            m_frame = wbuf;
            m_valid = 1;
            m_has   = 1;
        end
    endtask

    task automatic check_status(input string name);
        chk({name, "_valid"}, 64'(bus.frame_valid_o), 64'(m_valid));
        chk({name, "_overrun"}, 64'(bus.overrun_o), 64'(m_ovr));
        chk({name, "_peak_idx"}, 64'(bus.peak_idx_o), 64'(m_pidx));
        chk({name, "_peak_pwr"}, 64'(bus.peak_pwr_o), 64'(m_ppwr));
    endtask

    task automatic check_readback(input string name, input int first, input int last);
        logic [63:0] ed, ep;
        for (int a = first; a <= last; a++) begin
            bus.rd_addr_i = 5'(a);
            tick();
            ed = m_has ? m_frame[a] : 64'h0;
            ep = m_has ? {32'(lane_pwr(m_frame[a], 1)), 32'(lane_pwr(m_frame[a], 0))} : 64'h0;
            chk($sformatf("%s_data[%0d]", name, a), bus.rd_data_o, ed);
            chk($sformatf("%s_pwr[%0d]", name, a), bus.rd_pwr_o, ep);
        end
    endtask

    task automatic drive_edge();
        bus.next_out_i = 1'b1;
        tick();
        bus.next_out_i = 1'b0;
    endtask

    task automatic drive_words(input int ack_at);
        for (int k = 0; k < NWORDS; k++) begin
            bus.y_i = wbuf[k];
            bus.frame_ack_i = (k == ack_at);
            tick();
            if (k == ack_at) model_ack();
            bus.frame_ack_i = 1'b0;
        end
    endtask

    task automatic finish_frame(input string name, input bit ack_commit);
        tick();
        tick();
        chk({name, "_precommit_valid"}, 64'(bus.frame_valid_o), 64'(m_valid));
        if (ack_commit) begin
            bus.frame_ack_i = 1'b1;
            model_ack();
        end
        tick();
        bus.frame_ack_i = 1'b0;
        model_commit();
        check_status(name);
    endtask

    task automatic run_frame(input string name, input int ack_at, input bit ack_commit);
        drive_edge();
        drive_words(ack_at);
        finish_frame(name, ack_commit);
    endtask

    task automatic do_ack();
        bus.frame_ack_i = 1'b1;
        tick();
        bus.frame_ack_i = 1'b0;
        model_ack();
    endtask

    task automatic fill_zero();
        for (int k = 0; k < NWORDS; k++) wbuf[k] = '0;
    endtask

    function automatic logic [15:0] rand16();
        return ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
    endfunction

    task automatic fill_random();
        for (int k = 0; k < NWORDS; k++) wbuf[k] = {rand16(), rand16(), rand16(), rand16()};
    endtask

    initial begin
        vecs[0] = '{"extreme", 5, {16'h8000, 16'h8000, 16'h0000, 16'h0000},
                    5, {16'h8000, 16'h8000, 16'h0000, 16'h0000},
                    6'd11, 32'h8000_0000, {32'h8000_0000, 32'h0}};
        vecs[1] = '{"tie_bins", 3, {16'h0000, 16'h0000, 16'd8, 16'd6},
                    20, {16'h0000, 16'hFFF6, 16'h0000, 16'h0000},
                    6'd6, 32'd100, {32'd0, 32'd100}};
        vecs[2] = '{"lane_tie", 7, {16'h0000, 16'hFFFB, 16'd4, 16'd3},
                    7, {16'h0000, 16'hFFFB, 16'd4, 16'd3},
                    6'd14, 32'd25, {32'd25, 32'd25}};
        vecs[3] = '{"lane1_wins", 0, {16'd2, 16'h0000, 16'h0000, 16'd1},
                    0, {16'd2, 16'h0000, 16'h0000, 16'd1},
                    6'd1, 32'd4, {32'd4, 32'd1}};
        vecs[4] = '{"near_max", 30, {16'h0000, 16'h0000, 16'h8001, 16'h7FFF},
                    30, {16'h0000, 16'h0000, 16'h8001, 16'h7FFF},
                    6'd60, 32'h7FFE_0002, {32'd0, 32'h7FFE_0002}};

        rst_n = 1'b0;
        bus.next_out_i = 1'b0;
        bus.y_i = '0;
        bus.rd_addr_i = '0;
        bus.frame_ack_i = 1'b0;
        model_reset();
        fill_zero();
        repeat (3) tick();
        check_status("reset");
        chk("reset_rd_data", bus.rd_data_o, 64'h0);
        chk("reset_rd_pwr", bus.rd_pwr_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_ack();
        check_status("ack_idle");

        // Ramp frame: Y0 = k.
        fill_zero();
        for (int k = 0; k < NWORDS; k++) wbuf[k] = 64'(k);
        run_frame("ramp", -1, 0);
        chk("ramp_peak_idx", 64'(bus.peak_idx_o), 64'd62);
        chk("ramp_peak_pwr", 64'(bus.peak_pwr_o), 64'd961);
        bus.rd_addr_i = 5'd31;
        tick();
        chk("ramp_data31", bus.rd_data_o, 64'h1F);
        chk("ramp_pwr31", bus.rd_pwr_o, {32'd0, 32'd961});
        check_readback("ramp", 0, NWORDS - 1);

        // Directed single-point frames.
        for (int i = 0; i < 5; i++) begin
            if (m_valid) do_ack();
            fill_zero();
            wbuf[vecs[i].a] = vecs[i].ya;
            wbuf[vecs[i].b] = vecs[i].yb;
            run_frame(vecs[i].name, -1, 0);
            chk({vecs[i].name, "_idx"}, 64'(bus.peak_idx_o), 64'(vecs[i].eidx));
            chk({vecs[i].name, "_pwr"}, 64'(bus.peak_pwr_o), 64'(vecs[i].epwr));
            bus.rd_addr_i = 5'(vecs[i].a);
            tick();
            chk({vecs[i].name, "_rd_data"}, bus.rd_data_o, vecs[i].ya);
            chk({vecs[i].name, "_rd_pwr"}, bus.rd_pwr_o, vecs[i].epwr_a);
        end

        // Overrun: second frame dropped while the first is still held.
        do_ack();
        fill_random();
        run_frame("ovr_f1", -1, 0);
        fill_random();
        run_frame("ovr_f2", -1, 0);
        chk("ovr_flag", 64'(bus.overrun_o), 64'd1);
        check_readback("ovr_rb", 0, NWORDS - 1);
        do_ack();
        chk("ovr_ack_valid", 64'(bus.frame_valid_o), 64'd0);
        chk("ovr_ack_flag", 64'(bus.overrun_o), 64'd0);
        fill_random();
        run_frame("ovr_f3", -1, 0);
        chk("ovr_f3_valid", 64'(bus.frame_valid_o), 64'd1);
        check_readback("ovr_f3", 0, NWORDS - 1);

        // Restart at k=10: the aborted frame never commits.
        do_ack();
        fill_random();
        drive_edge();
        for (int k = 0; k < 10; k++) begin
            bus.y_i = wbuf[k];
            tick();
        end
        fill_random();
        run_frame("restart", -1, 0);
        check_readback("restart", 0, NWORDS - 1);

        // Ack coincident with COMMIT while overrun is set.
        fill_random();
        run_frame("pre_ovr", -1, 0);
        fill_random();
        run_frame("ack_commit", -1, 1);
        chk("ack_commit_valid", 64'(bus.frame_valid_o), 64'd1);
        chk("ack_commit_ovr", 64'(bus.overrun_o), 64'd0);
        check_readback("ack_commit", 0, NWORDS - 1);

        // Edge during COMMIT: frame A commits, frame B starts right away.
        do_ack();
        fill_random();
        drive_edge();
        drive_words(-1);
        tick();
        tick();
        drive_edge();
        model_commit();
        check_status("edge_commit_a");
        fill_random();
        drive_words(4);
        finish_frame("edge_commit_b", 0);
        check_readback("edge_commit_b", 0, NWORDS - 1);

        // Randomized frames with random acks.
        for (int it = 0; it < 6; it++) begin
            int ack_at;
            bit ackc;
            if ($urandom_range(0, 3) == 0) do_ack();
            fill_random();
            ack_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NWORDS - 1)) : -1;
            ackc = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rand%0d", it), ack_at, ackc);
            check_readback($sformatf("rand%0d", it), 0, NWORDS - 1);
        end

        // Asynchronous reset in the middle of a capture.
        do_ack();
        fill_random();
        run_frame("pre_reset", -1, 0);
        fill_random();
        drive_edge();
        for (int k = 0; k < 12; k++) begin
            bus.y_i = wbuf[k];
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_status("async_reset");
        chk("async_reset_rd_data", bus.rd_data_o, 64'h0);
        chk("async_reset_rd_pwr", bus.rd_pwr_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) tick();
        check_status("post_reset_idle");
        check_readback("post_reset", 0, 1);
        fill_random();
        run_frame("post_reset_frame", -1, 0);
        check_readback("post_reset_frame", 0, NWORDS - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
